// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file slice.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  // LSB position of port `port` inside a flattened bus of `width`-bit fields
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_file_wr_merge.sv
// Resolves all write ports into one per-register enable/data pair, highest port index winning.
// Combinational, 0 cycles; no backpressure, writes are always accepted.
module reg_file_wr_merge
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 2**ADDR_W
) (
  input  logic [NUM_WR-1:0]        wr_vld,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_dat,
  output logic [DEPTH-1:0]         merge_vld,
  output logic [DEPTH*DATA_W-1:0]  merge_dat
);

  logic [ADDR_W-1:0] port_addr [NUM_WR];

  for (genvar j = 0; j < NUM_WR; j++) begin : g_addr
    assign port_addr[j] = wr_addr[port_lsb(j, ADDR_W) +: ADDR_W];
  end

  // Ascending port order so a later (higher) port overwrites an earlier one
  always_comb begin
    merge_vld = '0;
    merge_dat = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_vld[j] && !(ZERO_REG != 0 && port_addr[j] == ADDR_W'(ZERO_ADDR))) begin
        merge_vld[port_addr[j]] = 1'b1;
        merge_dat[int'(port_addr[j]) * DATA_W +: DATA_W] = wr_dat[port_lsb(j, DATA_W) +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy scoreboard and busy count.
// Reads 0 cycles (optional write bypass), writes/claims land next edge; never stalls.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_reg_file_mp_clk,
  input  logic                     i_reg_file_mp_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_reg_file_mp_ra,
  output logic [NUM_RD*DATA_W-1:0] o_reg_file_mp_rd,
  output logic [NUM_RD-1:0]        o_reg_file_mp_rd_busy,
  input  logic [NUM_WR-1:0]        i_reg_file_mp_we,
  input  logic [NUM_WR*ADDR_W-1:0] i_reg_file_mp_wa,
  input  logic [NUM_WR*DATA_W-1:0] i_reg_file_mp_wd,
  input  logic                     i_reg_file_mp_claim,
  input  logic [ADDR_W-1:0]        i_reg_file_mp_claim_addr,
  output logic [ADDR_W:0]          o_reg_file_mp_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       regs [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        busy_nxt;
  logic [DEPTH-1:0]        claim_vec;
  logic [ADDR_W:0]         busy_cnt;
  logic [ADDR_W:0]         cnt_nxt;
  logic [DEPTH-1:0]        merge_vld;
  logic [DEPTH*DATA_W-1:0] merge_dat;
  logic [ADDR_W-1:0]       rd_addr [NUM_RD];

  reg_file_wr_merge #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH)
  ) u_wr_merge (
    .wr_vld    (i_reg_file_mp_we),
    .wr_addr   (i_reg_file_mp_wa),
    .wr_dat    (i_reg_file_mp_wd),
    .merge_vld (merge_vld),
    .merge_dat (merge_dat)
  );

  // Claim is applied after the write clear so a same-cycle claim keeps the register busy
  always_comb begin
    claim_vec = '0;
    if (i_reg_file_mp_claim &&
        !(ZERO_REG != 0 && i_reg_file_mp_claim_addr == ADDR_W'(ZERO_ADDR))) begin
      claim_vec[i_reg_file_mp_claim_addr] = 1'b1;
    end
    busy_nxt = (busy & ~merge_vld) | claim_vec;
    cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge i_reg_file_mp_clk) begin
    if (i_reg_file_mp_rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (merge_vld[i]) begin
          regs[i] <= merge_dat[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
    assign rd_addr[k] = i_reg_file_mp_ra[port_lsb(k, ADDR_W) +: ADDR_W];
  end

  always_comb begin
    o_reg_file_mp_rd      = '0;
    o_reg_file_mp_rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ZERO_REG != 0 && rd_addr[k] == ADDR_W'(ZERO_ADDR)) begin
        o_reg_file_mp_rd[port_lsb(k, DATA_W) +: DATA_W] = '0;
      end else if (BYPASS != 0 && merge_vld[rd_addr[k]]) begin
        o_reg_file_mp_rd[port_lsb(k, DATA_W) +: DATA_W] =
          merge_dat[int'(rd_addr[k]) * DATA_W +: DATA_W];
      end else begin
        o_reg_file_mp_rd[port_lsb(k, DATA_W) +: DATA_W] = regs[rd_addr[k]];
        o_reg_file_mp_rd_busy[k] = busy[rd_addr[k]];
      end
    end
  end

  assign o_reg_file_mp_busy_cnt = busy_cnt;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file with an integrated write-pending scoreboard, the next-generation replacement for the CPU's two-read/one-write register file. Serves N read ports and M write ports per cycle, with optional write-to-read bypass and a hard-wired zero register. Per-register busy bits let issue logic claim a destination register and stall readers until its writeback commits.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy

Ports:
- i_reg_file_mp_clk  in  1  clock, all state updates on rising edge
- i_reg_file_mp_rst  in  1  reset, synchronous, active-high
- i_reg_file_mp_ra  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- o_reg_file_mp_rd  out  NUM_RD*DATA_W  read data per port
- o_reg_file_mp_rd_busy  out  NUM_RD  busy flag of each read address
- i_reg_file_mp_we  in  NUM_WR  write enable per write port
- i_reg_file_mp_wa  in  NUM_WR*ADDR_W  write addresses
- i_reg_file_mp_wd  in  NUM_WR*DATA_W  write data
- i_reg_file_mp_claim  in  1  mark i_reg_file_mp_claim_addr busy
- i_reg_file_mp_claim_addr  in  ADDR_W  register claimed by issuing instruction
- o_reg_file_mp_busy_cnt  out  ADDR_W+1  number of busy registers

## Operation
- Reset: all registers 0, all busy bits 0, busy_cnt 0, effective at the edge where rst is sampled high; writes and claims in that cycle are discarded.
- Write: on edge with we[j]=1, reg[wa[j]] <= wd[j] and busy[wa[j]] <= 0. Two ports same address same cycle: higher port index wins data; busy cleared once.
- ZERO_REG=1: writes/claims to address 0 ignored; read of address 0 returns 0, busy 0.
- Claim: claim=1 sets busy[claim_addr]. Same-cycle claim and write to same address: data written, busy stays 1 (new producer owns it).
- Read (combinational): rd[k] = reg[ra[k]]. BYPASS=1 and any we[j] with wa[j]==ra[k] this cycle: rd[k] = wd of highest such j. rd_busy[k] = busy[ra[k]], forced 0 when BYPASS=1 and a write to ra[k] is present this cycle (unless ZERO_REG address 0, always 0). BYPASS=0: no forwarding; rd_busy reflects registered busy bit only.
- busy_cnt: registered popcount of busy bits; updated same edge as busy bits; never exceeds DEPTH (or DEPTH-1 with ZERO_REG).
- Claim of an already-busy register: busy stays 1, count unchanged.

## Timing
- Read latency 0 cycles (combinational from ra, state, and same-cycle write inputs when BYPASS=1).
- Write visible through non-bypassed path the cycle after the write edge.
- Claim -> rd_busy=1 the cycle after the claim edge; write -> rd_busy=0 same cycle (BYPASS=1) or next cycle (BYPASS=0).
- busy_cnt reflects state after the last edge; 1-cycle lag from claim/write inputs.
- Reset mid-operation: pending busy bits dropped; first post-reset cycle all reads 0, busy 0, count 0.
- No combinational path from claim inputs to any output.

## Structure
- Package reg_file_pkg: default parameter constants (DATA_W, ADDR_W), address-slice helper function, ZERO_ADDR constant.
- Sub-module reg_file_wr_merge: per-address write-port priority resolution producing final write enable/data and busy-clear vector; instantiated once, reused by bypass logic.
- Storage as flop array (no RAM inference required); scoreboard as DEPTH-bit vector plus count register.

## Test plan
- Reset then read all 32 addresses on both ports -> all rd=0, rd_busy=0, busy_cnt=0.
- Write 0xDEADBEEF to r5, read r5 same cycle -> BYPASS=1: rd=0xDEADBEEF; BYPASS=0: old value 0, next cycle 0xDEADBEEF.
- Claim r7, next cycle read r7 -> rd_busy=1, busy_cnt=1; write r7=0x12 -> rd_busy=0 same cycle (BYPASS=1), busy_cnt=0 next cycle.
- NUM_WR=2, both ports write r3 (0x1111 port0, 0x2222 port1) -> r3=0x2222; write r0=0xFFFF -> r0 reads 0, claim r0 -> busy_cnt unchanged.
- Same-cycle claim r9 and write r9=0x55 -> next cycle rd=0x55, rd_busy=1, busy_cnt=1.
- Claim r1,r2,r4 then assert rst together with write r1=0xAB -> next cycle r1 reads 0, all busy 0, busy_cnt=0.
